// File: rtl/pool2d_engine.sv
// Strided KxK max/average pooling over a CHW-linear map, read from conv BRAM and written to pool BRAM.
// Latency: done arrives N+BRAM_LAT+3 cycles after start (N = CHANNELS*OUT_SIZE^2*POOL^2 reads).
// No backpressure: one read per RUN cycle and one write per window. POOL2D_RELU_EN clamps results at 0.
module pool2d_engine #(
  parameter int DATA_WIDTH = 16,
  parameter int CHANNELS   = 2,
  parameter int IN_SIZE    = 4,
  parameter int POOL       = 2,
  parameter int STRIDE     = 2,
  parameter int BRAM_LAT   = 1,
  localparam int OUT_SIZE  = (IN_SIZE - POOL) / STRIDE + 1,
  localparam int CONV_AW   = (CHANNELS * IN_SIZE * IN_SIZE > 1) ? $clog2(CHANNELS * IN_SIZE * IN_SIZE) : 1,
  localparam int POOL_AW   = (CHANNELS * OUT_SIZE * OUT_SIZE > 1) ? $clog2(CHANNELS * OUT_SIZE * OUT_SIZE) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  mode,
  output logic [CONV_AW-1:0]    conv_addr,
  output logic                  conv_en,
  input  logic [DATA_WIDTH-1:0] conv_q,
  output logic [POOL_AW-1:0]    pool_addr,
  output logic                  pool_en,
  output logic                  pool_we,
  output logic [DATA_WIDTH-1:0] pool_d,
  output logic                  busy,
  output logic                  done
);

  localparam int N_RD  = CHANNELS * OUT_SIZE * OUT_SIZE * POOL * POOL;
  localparam int N_WR  = CHANNELS * OUT_SIZE * OUT_SIZE;
  localparam int SH    = 2 * $clog2(POOL);
  localparam int ACC_W = DATA_WIDTH + SH;
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int OS_W  = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1;
  localparam int K_W   = (POOL > 1) ? $clog2(POOL) : 1;
  localparam int RD_W  = $clog2(N_RD + 1);

  localparam logic [CH_W-1:0]    CH_LAST = CH_W'(CHANNELS - 1);
  localparam logic [OS_W-1:0]    O_LAST  = OS_W'(OUT_SIZE - 1);
  localparam logic [K_W-1:0]     K_LAST  = K_W'(POOL - 1);
  localparam logic [RD_W-1:0]    RD_N    = RD_W'(N_RD);
  localparam logic [POOL_AW-1:0] W_LAST  = POOL_AW'(N_WR - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  state_t               state;
  logic                 mode_r;
  logic [CH_W-1:0]      ch_c;
  logic [OS_W-1:0]      or_c, oc_c;
  logic [K_W-1:0]       kr_c, kc_c;
  logic [RD_W-1:0]      rd_cnt;
  logic                 first_tag, last_tag;
  logic                 issue;
  logic [CONV_AW-1:0]   rd_addr;

  logic [BRAM_LAT:0]    vld_p, first_p, last_p;
  logic signed [ACC_W-1:0] acc, q_ext, acc_next;
  logic [DATA_WIDTH-1:0] res;
  logic [POOL_AW-1:0]   wr_idx;

  // Read issue decision and the source address of the read the counters point at.
  always_comb begin
    issue   = ((state == S_IDLE) && start) || ((state == S_RUN) && (rd_cnt != RD_N));
    rd_addr = CONV_AW'(ch_c) * CONV_AW'(IN_SIZE * IN_SIZE)
            + (CONV_AW'(or_c) * CONV_AW'(STRIDE) + CONV_AW'(kr_c)) * CONV_AW'(IN_SIZE)
            + CONV_AW'(oc_c) * CONV_AW'(STRIDE) + CONV_AW'(kc_c);
  end

  // Control FSM plus read sequencer; counters wrap to zero after the final read of a run.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      mode_r    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      conv_en   <= 1'b0;
      conv_addr <= '0;
      first_tag <= 1'b0;
      last_tag  <= 1'b0;
      rd_cnt    <= '0;
      ch_c      <= '0;
      or_c      <= '0;
      oc_c      <= '0;
      kr_c      <= '0;
      kc_c      <= '0;
    end else begin
      conv_en <= issue;
      if (issue) begin
        conv_addr <= rd_addr;
        first_tag <= (kr_c == '0) && (kc_c == '0);
        last_tag  <= (kr_c == K_LAST) && (kc_c == K_LAST);
        rd_cnt    <= rd_cnt + 1'b1;
        if (kc_c == K_LAST) begin
          kc_c <= '0;
          if (kr_c == K_LAST) begin
            kr_c <= '0;
            if (oc_c == O_LAST) begin
              oc_c <= '0;
              if (or_c == O_LAST) begin
                or_c <= '0;
                ch_c <= (ch_c == CH_LAST) ? '0 : ch_c + 1'b1;
              end else begin
                or_c <= or_c + 1'b1;
              end
            end else begin
              oc_c <= oc_c + 1'b1;
            end
          end else begin
            kr_c <= kr_c + 1'b1;
          end
        end else begin
          kc_c <= kc_c + 1'b1;
        end
      end
      case (state)
        S_IDLE: if (start) begin
          state  <= S_RUN;
          busy   <= 1'b1;
          mode_r <= mode;
        end
        S_RUN: if (!issue) state <= S_DRAIN;
        S_DRAIN: if (pool_we && (pool_addr == W_LAST)) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state  <= S_IDLE;
          done   <= 1'b0;
          busy   <= 1'b0;
          rd_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Reduction of the element arriving this cycle into the running window value.
  always_comb begin
    q_ext = ACC_W'($signed(conv_q));
    if (first_p[BRAM_LAT])  acc_next = q_ext;
    else if (mode_r)        acc_next = acc + q_ext;
    else if (q_ext > acc)   acc_next = q_ext;
    else                    acc_next = acc;
    res = mode_r ? DATA_WIDTH'(acc_next >>> SH) : DATA_WIDTH'(acc_next);
`ifdef POOL2D_RELU_EN
    if (res[DATA_WIDTH-1]) res = '0;
`endif
  end

  // Tag pipeline matched to BRAM latency, accumulator, and one write per completed window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_p     <= '0;
      first_p   <= '0;
      last_p    <= '0;
      acc       <= '0;
      wr_idx    <= '0;
      pool_addr <= '0;
      pool_en   <= 1'b0;
      pool_we   <= 1'b0;
      pool_d    <= '0;
    end else begin
      vld_p[0]   <= conv_en;
      first_p[0] <= first_tag;
      last_p[0]  <= last_tag;
      for (int i = 1; i <= BRAM_LAT; i++) begin
        vld_p[i]   <= vld_p[i-1];
        first_p[i] <= first_p[i-1];
        last_p[i]  <= last_p[i-1];
      end
      if (vld_p[BRAM_LAT]) acc <= acc_next;
      if (vld_p[BRAM_LAT] && last_p[BRAM_LAT]) begin
        pool_en   <= 1'b1;
        pool_we   <= 1'b1;
        pool_d    <= res;
        pool_addr <= wr_idx;
        wr_idx    <= (wr_idx == W_LAST) ? '0 : wr_idx + 1'b1;
      end else begin
        pool_en <= 1'b0;
        pool_we <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pool2d_engine.sv
// Drives three engine configurations from one shared source memory and checks
// read order, write values/addresses/cycles, busy/done timing against a reference model.
module tb_pool2d_engine;

  logic clk = 1'b0;
  logic reset, start, mode;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   mem_data [0:31];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // instance 0: C2 P2 S2 L1; instance 1: C2 P3 S1 L2; instance 2: C1 P1 S1 L0
  logic [4:0]  a_conv_addr, b_conv_addr;
  logic [3:0]  c_conv_addr;
  logic        a_conv_en, b_conv_en, c_conv_en;
  logic [15:0] a_conv_q, b_conv_q, c_conv_q;
  logic [2:0]  a_pool_addr, b_pool_addr;
  logic [3:0]  c_pool_addr;
  logic        a_pool_en, b_pool_en, c_pool_en, a_pool_we, b_pool_we, c_pool_we;
  logic [15:0] a_pool_d, b_pool_d, c_pool_d;
  logic        a_busy, b_busy, c_busy, a_done, b_done, c_done;

  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(2), .STRIDE(2), .BRAM_LAT(1)) u_a (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .conv_addr(a_conv_addr), .conv_en(a_conv_en), .conv_q(a_conv_q),
    .pool_addr(a_pool_addr), .pool_en(a_pool_en), .pool_we(a_pool_we), .pool_d(a_pool_d),
    .busy(a_busy), .done(a_done));

  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(2), .IN_SIZE(4), .POOL(3), .STRIDE(1), .BRAM_LAT(2)) u_b (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .conv_addr(b_conv_addr), .conv_en(b_conv_en), .conv_q(b_conv_q),
    .pool_addr(b_pool_addr), .pool_en(b_pool_en), .pool_we(b_pool_we), .pool_d(b_pool_d),
    .busy(b_busy), .done(b_done));

  pool2d_engine #(.DATA_WIDTH(16), .CHANNELS(1), .IN_SIZE(4), .POOL(1), .STRIDE(1), .BRAM_LAT(0)) u_c (
    .clk(clk), .reset(reset), .start(start), .mode(mode),
    .conv_addr(c_conv_addr), .conv_en(c_conv_en), .conv_q(c_conv_q),
    .pool_addr(c_pool_addr), .pool_en(c_pool_en), .pool_we(c_pool_we), .pool_d(c_pool_d),
    .busy(c_busy), .done(c_done));

  // Source BRAM models: data appears 1+BRAM_LAT cycles after the address.
  logic [15:0] qa_p [0:1];
  logic [15:0] qb_p [0:2];
  logic [15:0] qc_p [0:0];
  always @(posedge clk) begin
    qa_p[0] <= 16'(mem_data[a_conv_addr]);
    qa_p[1] <= qa_p[0];
    qb_p[0] <= 16'(mem_data[b_conv_addr]);
    qb_p[1] <= qb_p[0];
    qb_p[2] <= qb_p[1];
    qc_p[0] <= 16'(mem_data[c_conv_addr]);
  end
  assign a_conv_q = qa_p[1];
  assign b_conv_q = qb_p[2];
  assign c_conv_q = qc_p[0];

  typedef struct {int inst; int addr; int dat; int cyc;} ev_t;
  ev_t wr_log[$];
  ev_t rd_log[$];
  int  done_cnt [3] = '{0, 0, 0};
  int  done_cyc [3] = '{0, 0, 0};
  int  busy_cnt [3] = '{0, 0, 0};

  // Output monitors, sampled on the falling edge.
  always @(negedge clk) begin
    if (a_conv_en) rd_log.push_back('{0, int'(a_conv_addr), 0, cyc});
    if (b_conv_en) rd_log.push_back('{1, int'(b_conv_addr), 0, cyc});
    if (c_conv_en) rd_log.push_back('{2, int'(c_conv_addr), 0, cyc});
    if (a_pool_we) wr_log.push_back('{0, int'(a_pool_addr), int'($signed(a_pool_d)), cyc});
    if (b_pool_we) wr_log.push_back('{1, int'(b_pool_addr), int'($signed(b_pool_d)), cyc});
    if (c_pool_we) wr_log.push_back('{2, int'(c_pool_addr), int'($signed(c_pool_d)), cyc});
    if (a_done) begin done_cnt[0] <= done_cnt[0] + 1; done_cyc[0] <= cyc; end
    if (b_done) begin done_cnt[1] <= done_cnt[1] + 1; done_cyc[1] <= cyc; end
    if (c_done) begin done_cnt[2] <= done_cnt[2] + 1; done_cyc[2] <= cyc; end
    if (a_busy) busy_cnt[0] <= busy_cnt[0] + 1;
    if (b_busy) busy_cnt[1] <= busy_cnt[1] + 1;
    if (c_busy) busy_cnt[2] <= busy_cnt[2] + 1;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic void cfg(input int i, output int c, output int p, output int s, output int l);
    case (i)
      0:       begin c = 2; p = 2; s = 2; l = 1; end
      1:       begin c = 2; p = 3; s = 1; l = 2; end
      default: begin c = 1; p = 1; s = 1; l = 0; end
    endcase
  endfunction

  // k-th source address: channel, out row, out col, kr, kc ordering.
  function automatic int ref_rd(input int i, input int k);
    int c, p, s, l, o;
    cfg(i, c, p, s, l);
    o = (4 - p) / s + 1;
    return (k / (p * p * o * o)) * 16 + (((k / (p * p * o)) % o) * s + (k / p) % p) * 4
           + ((k / (p * p)) % o) * s + k % p;
  endfunction

  // Pooled value of window w from the source memory.
  function automatic int ref_win(input int i, input int w, input logic m);
    int c, p, s, l, o, ch, r, cc, v, best, sum, q;
    cfg(i, c, p, s, l);
    o = (4 - p) / s + 1;
    ch = w / (o * o); r = (w / o) % o; cc = w % o;
    sum = 0; best = 0;
    for (int kr = 0; kr < p; kr++)
      for (int kc = 0; kc < p; kc++) begin
        v = mem_data[ch * 16 + (r * s + kr) * 4 + cc * s + kc];
        if ((kr == 0 && kc == 0) || v > best) best = v;
        sum += v;
      end
    if (m) begin
      q = sum / (p * p);
      if (sum < 0 && (sum % (p * p)) != 0) q = q - 1;
    end else begin
      q = best;
    end
`ifdef POOL2D_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  task automatic run_case(input string name, input logic m, input bit poke);
    int s, t, c, p, st, l, o, n, w, k, errs;
    int base_done [3];
    int base_busy [3];
    bit all_done;
    wr_log.delete();
    rd_log.delete();
    for (int i = 0; i < 3; i++) begin base_done[i] = done_cnt[i]; base_busy[i] = busy_cnt[i]; end
    @(negedge clk); start = 1'b1; mode = m; s = cyc;
    @(negedge clk); start = 1'b0;
    if (poke) begin
      repeat (2) @(negedge clk); mode = ~m;
      repeat (3) @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
      repeat (5) @(negedge clk); start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    t = 0; all_done = 1'b0;
    while (t < 400 && !all_done) begin
      @(negedge clk); t++;
      all_done = (done_cnt[0] > base_done[0]) && (done_cnt[1] > base_done[1]) && (done_cnt[2] > base_done[2]);
    end
    check($sformatf("%s timeout", name), t >= 400 ? 1 : 0, 0);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      cfg(i, c, p, st, l);
      o = (4 - p) / st + 1; n = c * o * o * p * p; w = c * o * o;
      check($sformatf("%s i%0d done_at", name, i), done_cyc[i] - s, n + l + 3);
      check($sformatf("%s i%0d done_pulses", name, i), done_cnt[i] - base_done[i], 1);
      check($sformatf("%s i%0d busy_cycles", name, i), busy_cnt[i] - base_busy[i], n + l + 3);
      k = 0; errs = 0;
      foreach (rd_log[j]) if (rd_log[j].inst == i) begin
        if (rd_log[j].addr != ref_rd(i, k) || rd_log[j].cyc != s + 1 + k) errs++;
        k++;
      end
      check($sformatf("%s i%0d reads", name, i), k, n);
      check($sformatf("%s i%0d read_addr_or_cycle_errs", name, i), errs, 0);
      k = 0;
      foreach (wr_log[j]) if (wr_log[j].inst == i) begin
        check($sformatf("%s i%0d w%0d addr", name, i, k), wr_log[j].addr, k % w);
        check($sformatf("%s i%0d w%0d cycle", name, i, k), wr_log[j].cyc - s, (k + 1) * p * p + l + 2);
        if (!(m && i == 1))
          check($sformatf("%s i%0d w%0d data", name, i, k), wr_log[j].dat, ref_win(i, k % w, m));
        k++;
      end
      check($sformatf("%s i%0d writes", name, i), k, w);
    end
  endtask

  task automatic reset_mid();
    int d0 [3];
    @(negedge clk); start = 1'b1; mode = 1'b0;
    @(negedge clk); start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_mid outs i0", int'(|{a_conv_addr, a_conv_en, a_pool_addr, a_pool_en, a_pool_we, a_pool_d, a_busy, a_done}), 0);
    check("rst_mid outs i1", int'(|{b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_pool_d, b_busy, b_done}), 0);
    check("rst_mid outs i2", int'(|{c_conv_addr, c_conv_en, c_pool_addr, c_pool_en, c_pool_we, c_pool_d, c_busy, c_done}), 0);
    wr_log.delete();
    rd_log.delete();
    for (int i = 0; i < 3; i++) d0[i] = done_cnt[i];
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (100) @(negedge clk);
    check("rst_mid writes_after", wr_log.size(), 0);
    check("rst_mid reads_after", rd_log.size(), 0);
    for (int i = 0; i < 3; i++)
      check($sformatf("rst_mid i%0d no_done", i), done_cnt[i] - d0[i], 0);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 32; i++) mem_data[i] = int'($urandom_range(0, 65535)) - 32768;
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; mode = 1'b0;
    for (int i = 0; i < 32; i++) mem_data[i] = 0;
    #1;
    check("reset outs i0", int'(|{a_conv_addr, a_conv_en, a_pool_addr, a_pool_en, a_pool_we, a_pool_d, a_busy, a_done}), 0);
    check("reset outs i1", int'(|{b_conv_addr, b_conv_en, b_pool_addr, b_pool_en, b_pool_we, b_pool_d, b_busy, b_done}), 0);
    check("reset outs i2", int'(|{c_conv_addr, c_conv_en, c_pool_addr, c_pool_en, c_pool_we, c_pool_d, c_busy, c_done}), 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // ramp on channel 0, random channel 1
    for (int i = 0; i < 16; i++) mem_data[i] = i;
    for (int i = 16; i < 32; i++) mem_data[i] = int'($urandom_range(0, 65535)) - 32768;
    run_case("ramp_max", 1'b0, 1'b0);
    run_case("ramp_avg", 1'b1, 1'b0);

    // negative ramp: first window {-1,-2,-5,-6}
    for (int i = 0; i < 32; i++) mem_data[i] = -(i + 1);
    run_case("neg_max", 1'b0, 1'b0);
    run_case("neg_avg", 1'b1, 1'b0);

    // signed extremes
    for (int i = 0; i < 32; i++) mem_data[i] = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
    run_case("ext_max", 1'b0, 1'b0);
    run_case("ext_avg", 1'b1, 1'b0);

    // abort and restart
    fill_random();
    reset_mid();
    run_case("after_rst", 1'b0, 1'b0);

    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_case($sformatf("rand%0d", r), logic'($urandom_range(0, 1)), 1'b0);
    end

    // start re-pulsed and mode toggled while busy
    fill_random();
    run_case("poke_max", 1'b0, 1'b1);
    run_case("poke_avg", 1'b1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pool2d_engine.md
# pool2d_engine

Parametrised 2-D pooling engine that succeeds the fixed 2x2 maxpool stage in the CNN datapath. It reads a CHW-linear feature map from the conv-output BRAM and writes a pooled CHW-linear map to the pool BRAM. Window size and stride are configurable, so windows may overlap, and a runtime mode selects max or average pooling. Reads stream one per cycle, and a valid pipeline matched to the source BRAM latency carries each read to the reduction stage.

## Interface
Parameters:
- DATA_WIDTH, 16: signed element width.
- CHANNELS, 2: number of feature-map channels.
- IN_SIZE, 4: input height/width (square).
- POOL, 2: window height/width K. Must satisfy 1 ≤ POOL ≤ IN_SIZE, and must be a power of two when average mode is used.
- STRIDE, 2: window step, ≥1. OUT_SIZE = (IN_SIZE-POOL)/STRIDE+1.
- BRAM_LAT, 1: extra source-BRAM read latency, ≥0.
- CONV_AW / POOL_AW: derived, $clog2 of CHANNELS·IN_SIZE² / CHANNELS·OUT_SIZE² (minimum 1).

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low.
- start  in  1  single-cycle run request.
- mode  in  1  0 = max, 1 = average. Sampled at accepted start.
- conv_addr  out  CONV_AW  source read address.
- conv_en  out  1  source read strobe.
- conv_q  in  DATA_WIDTH  signed source data.
- pool_addr  out  POOL_AW  destination write address.
- pool_en  out  1  destination enable.
- pool_we  out  1  destination write enable.
- pool_d  out  DATA_WIDTH  signed pooled value.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle completion pulse.

## Operation
- States:
  - IDLE --start--> RUN.
  - RUN --last read issued--> DRAIN.
  - DRAIN --final write issued--> DONE.
  - DONE --(1 cycle)--> IDLE.
- start outside IDLE is ignored. mode is latched on an accepted start.
- Read order: channel, then output row, then output col, then kr, then kc. Address = ch·IN_SIZE² + (or·STRIDE+kr)·IN_SIZE + oc·STRIDE+kc.
- conv_en is high on every RUN cycle, issuing exactly N = CHANNELS·OUT_SIZE²·POOL² reads back-to-back.
- The valid/last-of-window tags travel through a pipeline of depth 1+BRAM_LAT alongside each read.
- The reduction register resets on the first element of each window.
- Max mode: signed compare. Ties keep the earlier element.
- Average mode:
  - Accumulator width is DATA_WIDTH+2·$clog2(POOL), signed.
  - Result = sum >>> 2·$clog2(POOL), which floors toward −∞, truncated to DATA_WIDTH.
- Writes go to sequential addresses 0..CHANNELS·OUT_SIZE²−1, one per window. pool_en and pool_we are asserted together.
- Reset values: all outputs 0, state IDLE, pipelines cleared. Reset mid-run aborts with no done pulse and no further writes. The next start restarts from address 0.

## Timing
- A read issued in cycle t has conv_q valid in cycle t+1+BRAM_LAT. The engine samples it at the end of that cycle.
- The first read is issued in the cycle after start is sampled.
- A window's write cycle is the cycle after its final element is sampled.
- done is asserted exactly N+BRAM_LAT+3 cycles after the start cycle. busy is high for all cycles between start and done, inclusive of done.
- Consecutive windows write every POOL² cycles with no bubbles.
- POOL=1, STRIDE=1 is a pass-through copy with one write per read.

## Configuration
- POOL2D_RELU_EN defined: every pool_d is clamped to max(result, 0) after reduction and after the average shift.
- Undefined: pool_d is the raw reduction result, negatives included. The port list is identical in both builds.

## Test plan
- Max, IN 4, POOL 2, STRIDE 2, BRAM_LAT 1, ch0 = 0..15 → writes 5, 7, 13, 15 at addresses 0-3. 32 reads, 8 writes. done at cycle N+4=36.
- Average, same data, BRAM_LAT 0 → 2, 4, 10, 12. Window {−1,−2,−5,−6} → −4 (floor).
- Overlap: POOL 3, STRIDE 1, BRAM_LAT 2, ch0 = 0..15 → 10, 11, 14, 15. Read addresses begin 0, 1, 2, 4, 5, 6, 8, 9, 10, 1…
- Window {−1,−2,−5,−6} in max mode → −1 without POOL2D_RELU_EN, 0 with it. Signed extremes {−32768, 32767} → 32767.
- Reset asserted mid-RUN → all outputs 0 immediately and no done. A following start completes normally with correct results.
- start pulsed while busy, and mode toggled mid-run → both ignored. Single done pulse, outputs unchanged from the uninterrupted run.
